// File: rtl/sdr_init_ref_sched_if.sv
// SDRAM command-pin and refresh-handshake bundle for sdr_init_ref_sched.
// master: the init/refresh sequencer (drives the command pins and refresh status).
// slave : the controller / pin-mux side (supplies ref_gnt, observes the rest).
//
// Handshake: ref_req is high while the sequencer is idle and owes at least one
// refresh; ref_gnt is a level that the sequencer samples only while idle. Once
// ref_req & ref_gnt are seen together on a rising edge the sequencer takes the
// bus (own_cmd=1) and keeps it until the refresh sequence completes.
`timescale 1ns/1ps
interface sdr_init_ref_sched_if;
    logic        sdr_cs_n;
    logic        sdr_ras_n;
    logic        sdr_cas_n;
    logic        sdr_we_n;
    logic [11:0] sdr_addr;
    logic [1:0]  sdr_ba;
    logic        own_cmd;
    logic        init_done;
    logic        ref_req;
    logic        ref_gnt;
    logic [3:0]  ref_pend;
    logic        ref_overflow;

    modport master (
        output sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_addr, sdr_ba,
        output own_cmd, init_done, ref_req, ref_pend, ref_overflow,
        input  ref_gnt
    );

    modport slave (
        input  sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_addr, sdr_ba,
        input  own_cmd, init_done, ref_req, ref_pend, ref_overflow,
        output ref_gnt
    );
endinterface

// File: rtl/sdr_init_ref_sched.sv
// SDRAM power-up initialiser and periodic auto-refresh scheduler.
// Drives NOP -> PRECHARGE-ALL -> AUTO-REFRESH x INIT_REF_CNT -> MRS after reset,
// then borrows the command bus for one refresh per grant.
// Optional macro SDR_REF_BURST_EN: drain every pending refresh under one grant.
// T_RP, T_RFC and T_MRD must be at least 2 (each wait state lasts t-1 cycles).
`timescale 1ns/1ps
module sdr_init_ref_sched #(
    parameter int unsigned INIT_WAIT    = 500,
    parameter int unsigned T_RP         = 3,
    parameter int unsigned T_RFC        = 7,
    parameter int unsigned T_MRD        = 2,
    parameter int unsigned INIT_REF_CNT = 2,
    parameter int unsigned REF_INTERVAL = 780,
    parameter int unsigned REF_PEND_MAX = 8,
    parameter logic [11:0] MODE_REG     = 12'h033
) (
    input  logic                 sdram_clk,
    input  logic                 sdram_resetn,
    sdr_init_ref_sched_if.master bus,
    output logic [3:0]           fsm_state
);

    typedef enum logic [3:0] {
        RST_WAIT     = 4'd0,
        INIT_PRE     = 4'd1,
        PRE_WAIT     = 4'd2,
        INIT_REF     = 4'd3,
        REF_WAIT     = 4'd4,
        INIT_MRS     = 4'd5,
        MRS_WAIT     = 4'd6,
        IDLE         = 4'd7,
        RUN_PRE      = 4'd8,
        RUN_PRE_WAIT = 4'd9,
        RUN_REF      = 4'd10,
        RUN_REF_WAIT = 4'd11
    } state_t;

    localparam logic [15:0] INIT_WAIT_C  = 16'(INIT_WAIT);
    localparam logic [15:0] RP_LOAD      = 16'(T_RP - 2);
    localparam logic [15:0] RFC_LOAD     = 16'(T_RFC - 2);
    localparam logic [15:0] MRD_LOAD     = 16'(T_MRD - 2);
    localparam logic [15:0] TIMER_LAST   = 16'(REF_INTERVAL - 1);
    localparam logic [3:0]  INIT_REFS    = 4'(INIT_REF_CNT);
    localparam logic [3:0]  PEND_MAX     = 4'(REF_PEND_MAX);
    localparam logic [11:0] PRE_ALL_ADDR = 12'h400;

    state_t      state;
    logic [15:0] wait_cnt;   // counts up in RST_WAIT, down in the other wait states
    logic [3:0]  init_refs;
    logic [15:0] ref_timer;

    logic        cs_n_q, ras_n_q, cas_n_q, we_n_q;
    logic [11:0] addr_q;
    logic [1:0]  ba_q;
    logic        own_q, init_done_q, ref_req_q, ref_ovf_q;
    logic [3:0]  ref_pend_q;

    logic        tick;
    logic        ref_issue;
    logic        burst_more;
    logic [3:0]  pend_nxt;
    logic        ovf_set;

`ifdef SDR_REF_BURST_EN
    assign burst_more = (ref_pend_q != 4'd0);
`else
    assign burst_more = 1'b0;
`endif

    // Refresh tick, run-time refresh issue, and the next pending count.
    always_comb begin
        tick      = init_done_q && (ref_timer == TIMER_LAST);
        ref_issue = (wait_cnt == 16'd0) &&
                    ((state == RUN_PRE_WAIT) || ((state == RUN_REF_WAIT) && burst_more));
        pend_nxt  = ref_pend_q;
        ovf_set   = 1'b0;
        if (tick && !ref_issue) begin
            if (ref_pend_q == PEND_MAX) begin
                ovf_set = 1'b1;
            end else begin
                pend_nxt = ref_pend_q + 4'd1;
            end
        end else if (!tick && ref_issue) begin
            pend_nxt = ref_pend_q - 4'd1;
        end
    end

    // Interval timer (held at zero until init completes) and pending-refresh bookkeeping.
    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            ref_timer  <= 16'd0;
            ref_pend_q <= 4'd0;
            ref_ovf_q  <= 1'b0;
        end else begin
            if (!init_done_q || tick) begin
                ref_timer <= 16'd0;
            end else begin
                ref_timer <= ref_timer + 16'd1;
            end
            ref_pend_q <= pend_nxt;
            if (ovf_set) begin
                ref_ovf_q <= 1'b1;
            end
        end
    end

    // Sequencer: outputs are registered alongside the state they belong to.
    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            state       <= RST_WAIT;
            wait_cnt    <= 16'd0;
            init_refs   <= 4'd0;
            cs_n_q      <= 1'b1;
            ras_n_q     <= 1'b1;
            cas_n_q     <= 1'b1;
            we_n_q      <= 1'b1;
            addr_q      <= 12'd0;
            ba_q        <= 2'd0;
            own_q       <= 1'b1;
            init_done_q <= 1'b0;
            ref_req_q   <= 1'b0;
        end else begin
            // Default: selected NOP while the bus is ours.
            cs_n_q    <= 1'b0;
            ras_n_q   <= 1'b1;
            cas_n_q   <= 1'b1;
            we_n_q    <= 1'b1;
            addr_q    <= 12'd0;
            ba_q      <= 2'd0;
            own_q     <= 1'b1;
            ref_req_q <= 1'b0;
            case (state)
                RST_WAIT: begin
                    if (wait_cnt == INIT_WAIT_C) begin
                        state   <= INIT_PRE;
                        ras_n_q <= 1'b0;
                        we_n_q  <= 1'b0;
                        addr_q  <= PRE_ALL_ADDR;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                INIT_PRE: begin
                    state    <= PRE_WAIT;
                    wait_cnt <= RP_LOAD;
                end
                PRE_WAIT: begin
                    if (wait_cnt == 16'd0) begin
                        state     <= INIT_REF;
                        ras_n_q   <= 1'b0;
                        cas_n_q   <= 1'b0;
                        init_refs <= init_refs + 4'd1;
                    end else begin
                        wait_cnt <= wait_cnt - 16'd1;
                    end
                end
                INIT_REF: begin
                    state    <= REF_WAIT;
                    wait_cnt <= RFC_LOAD;
                end
                REF_WAIT: begin
                    if (wait_cnt == 16'd0) begin
                        ras_n_q <= 1'b0;
                        cas_n_q <= 1'b0;
                        if (init_refs == INIT_REFS) begin
                            state  <= INIT_MRS;
                            we_n_q <= 1'b0;
                            addr_q <= MODE_REG;
                        end else begin
                            state     <= INIT_REF;
                            init_refs <= init_refs + 4'd1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 16'd1;
                    end
                end
                INIT_MRS: begin
                    state    <= MRS_WAIT;
                    wait_cnt <= MRD_LOAD;
                end
                MRS_WAIT: begin
                    if (wait_cnt == 16'd0) begin
                        state       <= IDLE;
                        init_done_q <= 1'b1;
                        own_q       <= 1'b0;
                        cs_n_q      <= 1'b1;
                        ref_req_q   <= (pend_nxt != 4'd0);
                    end else begin
                        wait_cnt <= wait_cnt - 16'd1;
                    end
                end
                IDLE: begin
                    if (ref_req_q && bus.ref_gnt) begin
                        state   <= RUN_PRE;
                        ras_n_q <= 1'b0;
                        we_n_q  <= 1'b0;
                        addr_q  <= PRE_ALL_ADDR;
                    end else begin
                        own_q     <= 1'b0;
                        cs_n_q    <= 1'b1;
                        ref_req_q <= (pend_nxt != 4'd0);
                    end
                end
                RUN_PRE: begin
                    state    <= RUN_PRE_WAIT;
                    wait_cnt <= RP_LOAD;
                end
                RUN_PRE_WAIT: begin
                    if (wait_cnt == 16'd0) begin
                        state   <= RUN_REF;
                        ras_n_q <= 1'b0;
                        cas_n_q <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt - 16'd1;
                    end
                end
                RUN_REF: begin
                    state    <= RUN_REF_WAIT;
                    wait_cnt <= RFC_LOAD;
                end
                RUN_REF_WAIT: begin
                    if (wait_cnt == 16'd0) begin
                        if (burst_more) begin
                            state   <= RUN_REF;
                            ras_n_q <= 1'b0;
                            cas_n_q <= 1'b0;
                        end else begin
                            state     <= IDLE;
                            own_q     <= 1'b0;
                            cs_n_q    <= 1'b1;
                            ref_req_q <= (pend_nxt != 4'd0);
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 16'd1;
                    end
                end
                default: begin
                    state <= RST_WAIT;
                end
            endcase
        end
    end

    assign fsm_state        = state;
    assign bus.sdr_cs_n     = cs_n_q;
    assign bus.sdr_ras_n    = ras_n_q;
    assign bus.sdr_cas_n    = cas_n_q;
    assign bus.sdr_we_n     = we_n_q;
    assign bus.sdr_addr     = addr_q;
    assign bus.sdr_ba       = ba_q;
    assign bus.own_cmd      = own_q;
    assign bus.init_done    = init_done_q;
    assign bus.ref_req      = ref_req_q;
    assign bus.ref_pend     = ref_pend_q;
    assign bus.ref_overflow = ref_ovf_q;

endmodule

// File: tb/tb_sdr_init_ref_sched.sv
// Bench for sdr_init_ref_sched: timeline reference model, per-cycle compare,
// directed grant phases, random grants, and mid-init reset replay.
`timescale 1ns/1ps
module tb_sdr_init_ref_sched;
    localparam int INIT_WAIT    = 500;
    localparam int T_RP         = 3;
    localparam int T_RFC        = 7;
    localparam int T_MRD        = 2;
    localparam int INIT_REF_CNT = 2;
    localparam int REF_INTERVAL = 780;
    localparam int REF_PEND_MAX = 8;
    localparam logic [11:0] MODE_REG = 12'h033;

    localparam int PRE_CYC  = INIT_WAIT;
    localparam int REF0_CYC = INIT_WAIT + T_RP;
    localparam int MRS_CYC  = REF0_CYC + INIT_REF_CNT * T_RFC;
    localparam int DONE_CYC = MRS_CYC + T_MRD;
`ifdef SDR_REF_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    localparam logic [2:0] C_NOP = 3'b111;
    localparam logic [2:0] C_PRE = 3'b010;
    localparam logic [2:0] C_REF = 3'b001;
    localparam logic [2:0] C_MRS = 3'b000;

    // Clock and reset
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] fsm_state;
    always #5 clk = ~clk;

    sdr_init_ref_sched_if bus();

    sdr_init_ref_sched #(
        .INIT_WAIT(INIT_WAIT), .T_RP(T_RP), .T_RFC(T_RFC), .T_MRD(T_MRD),
        .INIT_REF_CNT(INIT_REF_CNT), .REF_INTERVAL(REF_INTERVAL),
        .REF_PEND_MAX(REF_PEND_MAX), .MODE_REG(MODE_REG)
    ) dut (
        .sdram_clk(clk),
        .sdram_resetn(rst_n),
        .bus(bus),
        .fsm_state(fsm_state)
    );

    // Scoreboard counters
    int n_cmp = 0;
    int n_bad = 0;
    int n_print = 0;
    int cyc = -1;     // cycle index since reset release of the outputs now visible
    int epoch = 0;    // how many reset releases have happened

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_print < 40) begin
                n_print++;
                $display("FAIL %s epoch=%0d cycle=%0d got=%0h want=%0h", name, epoch, cyc, act, exp);
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cmd"}, {bus.sdr_cs_n, bus.sdr_ras_n, bus.sdr_cas_n, bus.sdr_we_n, bus.sdr_addr, bus.sdr_ba},
              {4'hF, 12'h000, 2'b00});
        check({tag, "_status"}, {bus.own_cmd, bus.init_done, bus.ref_req, bus.ref_pend, bus.ref_overflow},
              {1'b1, 1'b0, 1'b0, 4'h0, 1'b0});
    endtask

    function automatic logic [3:0] cmd4();
        return {bus.sdr_cs_n, bus.sdr_ras_n, bus.sdr_cas_n, bus.sdr_we_n};
    endfunction

    // Reference model: event timeline for init and for each borrowed refresh.
    int  m_pend;
    bit  m_ovf, m_idle, m_req, m_after_pre;
    int  m_ev;

    always @(posedge clk) begin
        logic g, rst_now, tick, issue, start, fin;
        logic [2:0] e_cmd;
        int k;
        g = bus.ref_gnt;
        rst_now = rst_n;
        #1;
        if (!rst_now) begin
            cyc = -1;
            m_pend = 0; m_ovf = 0; m_idle = 0; m_req = 0; m_after_pre = 0; m_ev = 0;
            check_reset_values("in_reset");
        end else begin
            cyc++;
            if (cyc == 0) epoch++;
            k = cyc;
            e_cmd = C_NOP;
            tick = 0; issue = 0; start = 0; fin = 0;
            if (k < DONE_CYC) begin
                m_idle = 0; m_pend = 0; m_ovf = 0;
                if (k == PRE_CYC) e_cmd = C_PRE;
                else if (k == MRS_CYC) e_cmd = C_MRS;
                else if (k >= REF0_CYC && k < MRS_CYC && ((k - REF0_CYC) % T_RFC) == 0) e_cmd = C_REF;
            end else if (k == DONE_CYC) begin
                m_idle = 1;
            end else begin
                tick = (((k - DONE_CYC) % REF_INTERVAL) == 0);
                if (m_idle) begin
                    if (m_req && g) start = 1;
                end else if (k == m_ev) begin
                    if (m_after_pre || (BURST && m_pend > 0)) begin
                        issue = 1; m_after_pre = 0; m_ev = k + T_RFC;
                    end else begin
                        fin = 1;
                    end
                end
                if (tick && !issue) begin
                    if (m_pend == REF_PEND_MAX) m_ovf = 1;
                    else m_pend++;
                end else if (!tick && issue) begin
                    m_pend--;
                end
                if (start) begin
                    m_idle = 0; m_after_pre = 1; m_ev = k + T_RP; e_cmd = C_PRE;
                end
                if (issue) e_cmd = C_REF;
                if (fin) m_idle = 1;
            end
            m_req = m_idle && (m_pend != 0);

            check("own_cmd", bus.own_cmd, !m_idle);
            check("init_done", bus.init_done, k >= DONE_CYC);
            check("ref_req", bus.ref_req, m_req);
            check("ref_pend", bus.ref_pend, m_pend);
            check("ref_overflow", bus.ref_overflow, m_ovf);
            if (!m_idle) begin
                check("cmd", cmd4(), {1'b0, e_cmd});
                if (e_cmd == C_PRE) check("pre_a10", bus.sdr_addr[10], 1'b1);
                if (e_cmd == C_MRS) check("mrs_addr_ba", {bus.sdr_addr, bus.sdr_ba}, {MODE_REG, 2'b00});
            end

            // Hand-computed pins on the init sequence (every init run).
            if (k == 499) check("lit_nop_499", cmd4(), 4'b0111);
            if (k == 500) check("lit_pre_500", {cmd4(), bus.sdr_addr[10]}, 5'b0_0101);
            if (k == 503) check("lit_ref_503", cmd4(), 4'b0001);
            if (k == 510) check("lit_ref_510", cmd4(), 4'b0001);
            if (k == 517) check("lit_mrs_517", {cmd4(), bus.sdr_addr}, {4'b0000, 12'h033});
            if (k == 519) check("lit_done_519", {bus.init_done, bus.own_cmd}, 2'b10);
            // Hand-computed pins on the directed refresh phases (first run only).
            if (epoch == 1) begin
                if (k == 1298) check("lit_req_1298", bus.ref_req, 1'b0);
                if (k == 1299) check("lit_req_1299", {bus.ref_req, bus.ref_pend}, 5'b1_0001);
                if (k == 1300) check("lit_pre_1300", cmd4(), 4'b0010);
                if (k == 1303) check("lit_ref_1303", {cmd4(), bus.ref_pend}, 8'b0001_0000);
                if (k == 1309) check("lit_own_1309", bus.own_cmd, 1'b1);
                if (k == 1310) check("lit_own_1310", bus.own_cmd, 1'b0);
                if (k == 2859) check("lit_coinc_2859", {cmd4(), bus.ref_pend}, 8'b0001_0001);
                if (k == 2866) check("lit_reassert_2866", {bus.own_cmd, bus.ref_req, bus.ref_pend}, 6'b01_0001);
                if (k == 8319) check("lit_sat_8319", {bus.ref_pend, bus.ref_overflow}, 5'b1000_0);
                if (k == 9099) check("lit_ovf_9099", {bus.ref_pend, bus.ref_overflow}, 5'b1000_1);
                if (k == 9110) check("lit_pre_9110", cmd4(), 4'b0010);
                if (k == 9113) check("lit_ref_9113", {cmd4(), bus.ref_pend}, 8'b0001_0111);
                if (k == 9117) check("lit_no_pre_9117", {bus.own_cmd, cmd4()}, 5'b1_0111);
`ifdef SDR_REF_BURST_EN
                if (k == 9120) check("lit_burst_9120", {cmd4(), bus.ref_pend}, 8'b0001_0110);
                if (k == 9162) check("lit_burst_last", {cmd4(), bus.ref_pend}, 8'b0001_0000);
                if (k == 9169) check("lit_burst_done", {bus.own_cmd, bus.ref_pend}, 5'b0_0000);
`else
                if (k == 9120) check("lit_single_9120", {bus.own_cmd, bus.ref_req, bus.ref_pend}, 6'b01_0111);
`endif
            end
        end
    end

    // Driver tasks
    task automatic at_cycle(input int n);
        int guard;
        guard = 0;
        while (cyc != n && guard < 30000) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++;
        if (cyc != n) begin
            n_bad++;
            $display("FAIL wait_cycle got=%0d want=%0d", cyc, n);
        end
    endtask

    task automatic random_grants(input int from_c, input int to_c);
        for (int c = from_c; c < to_c; c++) begin
            bus.ref_gnt = ($urandom_range(0, 3) == 0);
            at_cycle(c + 1);
        end
    endtask

    initial begin
        bus.ref_gnt = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Grant held through init and the first refresh.
        at_cycle(1304);
        bus.ref_gnt = 1'b0;
        // One-cycle grant so the run's REF lands on the next tick.
        at_cycle(2855);
        bus.ref_gnt = 1'b1;
        at_cycle(2856);
        bus.ref_gnt = 1'b0;
        // Starve until saturation and overflow, then grant once.
        at_cycle(9109);
        bus.ref_gnt = 1'b1;
        at_cycle(9110);
        bus.ref_gnt = 1'b0;
        // Stray grant pulse inside the refresh wait.
        at_cycle(9115);
        bus.ref_gnt = 1'b1;
        at_cycle(9116);
        bus.ref_gnt = 1'b0;
        at_cycle(9200);
        random_grants(9200, 12000);

        // Reset mid-run, then again between the init refreshes.
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset_run");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        at_cycle(505);
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset_init");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        at_cycle(600);
        random_grants(600, 3000);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
